// File: rtl/rtc_arb_defs.sv
// rtc_arb_defs: shared state encodings, channel IDs and the round-robin pick for the RTC bus arbiter.
package rtc_arb_defs;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] SELECT  = 3'd1;
    localparam logic [2:0] START   = 3'd2;
    localparam logic [2:0] WAIT    = 3'd3;
    localparam logic [2:0] RELEASE = 3'd4;

    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    // On a tie the channel that did not own the bus last time wins.
    function automatic logic pick(input logic r0, input logic r1, input logic last);
        return (r0 && r1) ? ~last : r1;
    endfunction

endpackage

// File: rtl/rtc_arb_timer.sv
// rtc_arb_timer: WAIT-phase cycle counter, flags expiry on the LIMIT-th counted cycle.
module rtc_arb_timer #(
    parameter int W     = 8,
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en) cnt <= cnt + 1'b1;
    end

    assign expired = cnt == W'(LIMIT - 1);

endmodule

// File: rtl/rtc_bus_arbiter.sv
// rtc_bus_arbiter: round-robin owner of the shared RTC bus engine for the read-refresh and write/config sequencers.
// Every output is a flop loaded from next-state values, so nothing combinational reaches the pins.
module rtc_bus_arbiter
    import rtc_arb_defs::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic done,
    output logic grant0,
    output logic grant1,
    output logic sel_mux,
    output logic bus_start,
    output logic busy,
    output logic timeout_err
);

    logic [2:0] state, state_nxt;
    logic last_grant, win, take, sel_nxt, active_nxt, expired, to_fire;

    assign win        = pick(req0, req1, last_grant);
    assign take       = (state == IDLE) && (req0 || req1);
    assign sel_nxt    = take ? win : sel_mux;
    assign active_nxt = state_nxt inside {SELECT, START, WAIT};
    assign to_fire    = (state == WAIT) && !done && expired;

    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = take ? SELECT : IDLE;
            SELECT:  state_nxt = START;
            START:   state_nxt = WAIT;
            WAIT:    state_nxt = (done || expired) ? RELEASE : WAIT;
            default: state_nxt = IDLE;
        endcase
    end

    generate
        if (TIMEOUT_CYCLES != 0) begin : g_timer
            rtc_arb_timer #(.W(TO_W), .LIMIT(TIMEOUT_CYCLES)) u_timer (
                .clk    (clk),
                .reset  (reset),
                .clr    (state == START),
                .en     ((state == WAIT) && !done),
                .expired(expired)
            );
        end else begin : g_no_timer
            assign expired = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            last_grant  <= CH1;
            sel_mux     <= CH0;
            grant0      <= 1'b0;
            grant1      <= 1'b0;
            bus_start   <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            if (take) last_grant <= win;
            sel_mux     <= sel_nxt;
            grant0      <= active_nxt && (sel_nxt == CH0);
            grant1      <= active_nxt && (sel_nxt == CH1);
            bus_start   <= state_nxt == START;
            busy        <= state_nxt != IDLE;
            timeout_err <= to_fire;
        end
    end

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// tb_rtc_bus_arbiter: directed scenarios on a default-timeout instance (a) and a TIMEOUT_CYCLES=4 instance (b).
module tb_rtc_bus_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic req0 = 1'b0, req1 = 1'b0, done = 1'b0;
    logic req0b = 1'b0, req1b = 1'b0, doneb = 1'b0;
    logic a_g0, a_g1, a_sel, a_bs, a_busy, a_err;
    logic b_g0, b_g1, b_sel, b_bs, b_busy, b_err;
    int n_cmp = 0, n_bad = 0;
    int norder, overlap;
    logic ord[4], selr[4], idl[4];

    always #5 clk = ~clk;

    rtc_bus_arbiter dut_a (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1), .done(done),
        .grant0(a_g0), .grant1(a_g1), .sel_mux(a_sel), .bus_start(a_bs),
        .busy(a_busy), .timeout_err(a_err)
    );

    rtc_bus_arbiter #(.TIMEOUT_CYCLES(4), .TO_W(3)) dut_b (
        .clk(clk), .reset(reset), .req0(req0b), .req1(req1b), .done(doneb),
        .grant0(b_g0), .grant1(b_g1), .sel_mux(b_sel), .bus_start(b_bs),
        .busy(b_busy), .timeout_err(b_err)
    );

    task automatic do_reset();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
    endtask

    // Acts as requester and bus engine for instance a: done follows one cycle after bus_start.
    task automatic run_a(input int n, input bit drop0, input bit drop1, input bit raise0);
        logic prev_any = 1'b0, prev_bs = 1'b0, idle_since = 1'b0;
        norder = 0; overlap = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (a_g0 && a_g1) overlap++;
            if ((a_g0 || a_g1) && !prev_any && norder < 4) begin
                ord[norder] = a_g1; selr[norder] = a_sel; idl[norder] = idle_since;
                norder++; idle_since = 1'b0;
            end
            if (!a_busy) idle_since = 1'b1;
            prev_any = a_g0 | a_g1;
            if (drop0 && a_g0) req0 = 1'b0;
            if (drop1 && a_g1) req1 = 1'b0;
            if (raise0 && prev_bs && norder == 1) req0 = 1'b1;
            done = prev_bs;
            prev_bs = a_bs;
        end
        done = 1'b0;
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if ({a_g0, a_g1, a_sel, a_bs, a_busy, a_err} !== 6'b0) begin n_bad++; $display("FAIL reset_outs_a: got %b want 000000", {a_g0, a_g1, a_sel, a_bs, a_busy, a_err}); end
        n_cmp++; if ({b_g0, b_g1, b_sel, b_bs, b_busy, b_err} !== 6'b0) begin n_bad++; $display("FAIL reset_outs_b: got %b want 000000", {b_g0, b_g1, b_sel, b_bs, b_busy, b_err}); end
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (a_busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle_busy: got %b want 0", a_busy); end
    endtask

    task automatic test_single();
        int busy_cnt = 0, bs_cnt = 0, bs_idx = -1, err_cnt = 0;
        logic g0_0, g1_0, sel_0, g0_5, g0_6, busy_7;
        req0 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (a_busy) busy_cnt++;
            if (a_bs) begin bs_cnt++; bs_idx = i; end
            if (a_err) err_cnt++;
            if (i == 0) begin g0_0 = a_g0; g1_0 = a_g1; sel_0 = a_sel; req0 = 1'b0; end
            if (i == 5) g0_5 = a_g0;
            if (i == 6) g0_6 = a_g0;
            if (i == 7) busy_7 = a_busy;
            done = (i == 5);
        end
        done = 1'b0;
        n_cmp++; if (g0_0 !== 1'b1) begin n_bad++; $display("FAIL single_grant0_latency: got %b want 1", g0_0); end
        n_cmp++; if (g1_0 !== 1'b0) begin n_bad++; $display("FAIL single_grant1_low: got %b want 0", g1_0); end
        n_cmp++; if (sel_0 !== 1'b0) begin n_bad++; $display("FAIL single_sel: got %b want 0", sel_0); end
        n_cmp++; if (bs_cnt !== 1) begin n_bad++; $display("FAIL single_start_count: got %0d want 1", bs_cnt); end
        n_cmp++; if (bs_idx !== 1) begin n_bad++; $display("FAIL single_start_cycle: got %0d want 1", bs_idx); end
        n_cmp++; if (g0_5 !== 1'b1) begin n_bad++; $display("FAIL single_wait_grant: got %b want 1", g0_5); end
        n_cmp++; if (g0_6 !== 1'b0) begin n_bad++; $display("FAIL single_release_grant: got %b want 0", g0_6); end
        n_cmp++; if (busy_7 !== 1'b0) begin n_bad++; $display("FAIL single_idle_busy: got %b want 0", busy_7); end
        n_cmp++; if (busy_cnt !== 7) begin n_bad++; $display("FAIL single_busy_cycles: got %0d want 7", busy_cnt); end
        n_cmp++; if (err_cnt !== 0) begin n_bad++; $display("FAIL single_timeout_err: got %0d want 0", err_cnt); end
    endtask

    task automatic test_tie();
        do_reset();
        req0 = 1'b1; req1 = 1'b1;
        run_a(10, 1'b1, 1'b1, 1'b0);
        n_cmp++; if (norder !== 2) begin n_bad++; $display("FAIL tie_grant_count: got %0d want 2", norder); end
        n_cmp++; if ({ord[0], ord[1]} !== 2'b01) begin n_bad++; $display("FAIL tie_order: got %b want 01", {ord[0], ord[1]}); end
        n_cmp++; if ({selr[0], selr[1]} !== 2'b01) begin n_bad++; $display("FAIL tie_sel: got %b want 01", {selr[0], selr[1]}); end
        n_cmp++; if (idl[1] !== 1'b1) begin n_bad++; $display("FAIL tie_idle_gap: got %b want 1", idl[1]); end
        n_cmp++; if (overlap !== 0) begin n_bad++; $display("FAIL tie_overlap: got %0d want 0", overlap); end
        n_cmp++; if (a_busy !== 1'b0) begin n_bad++; $display("FAIL tie_end_idle: got %b want 0", a_busy); end
    endtask

    task automatic test_round_robin();
        req1 = 1'b1;
        run_a(14, 1'b1, 1'b0, 1'b1);
        req1 = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (norder !== 3) begin n_bad++; $display("FAIL rr_grant_count: got %0d want 3", norder); end
        n_cmp++; if ({ord[0], ord[1], ord[2]} !== 3'b101) begin n_bad++; $display("FAIL rr_order: got %b want 101", {ord[0], ord[1], ord[2]}); end
        n_cmp++; if ({idl[1], idl[2]} !== 2'b11) begin n_bad++; $display("FAIL rr_idle_gap: got %b want 11", {idl[1], idl[2]}); end
        n_cmp++; if (overlap !== 0) begin n_bad++; $display("FAIL rr_overlap: got %0d want 0", overlap); end
    endtask

    task automatic test_timeout();
        int err_cnt = 0, err_idx = -1;
        logic prev_bs = 1'b0, g0_5, g0_6, busy_6, g1_8, g1_11;
        req0b = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 0) req0b = 1'b0;
            if (b_err) begin err_cnt++; err_idx = i; end
            if (i == 5) g0_5 = b_g0;
            if (i == 6) begin g0_6 = b_g0; busy_6 = b_busy; end
            if (i == 7) req1b = 1'b1;
            if (i == 8) begin g1_8 = b_g1; req1b = 1'b0; end
            if (i == 11) g1_11 = b_g1;
            doneb = (i >= 7) && prev_bs;
            prev_bs = b_bs;
        end
        doneb = 1'b0;
        n_cmp++; if (g0_5 !== 1'b1) begin n_bad++; $display("FAIL to_wait4_grant: got %b want 1", g0_5); end
        n_cmp++; if (g0_6 !== 1'b0) begin n_bad++; $display("FAIL to_release_grant: got %b want 0", g0_6); end
        n_cmp++; if (busy_6 !== 1'b1) begin n_bad++; $display("FAIL to_release_busy: got %b want 1", busy_6); end
        n_cmp++; if (err_cnt !== 1) begin n_bad++; $display("FAIL to_err_pulses: got %0d want 1", err_cnt); end
        n_cmp++; if (err_idx !== 6) begin n_bad++; $display("FAIL to_err_cycle: got %0d want 6", err_idx); end
        n_cmp++; if (g1_8 !== 1'b1) begin n_bad++; $display("FAIL to_next_grant: got %b want 1", g1_8); end
        n_cmp++; if (g1_11 !== 1'b0) begin n_bad++; $display("FAIL to_next_release: got %b want 0", g1_11); end
    endtask

    task automatic test_done_edges();
        int err_cnt = 0;
        logic bs_1, g0_3, g0_5, g0_6, busy_6;
        @(negedge clk);
        req0b = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (i == 0) req0b = 1'b0;
            if (b_err) err_cnt++;
            if (i == 1) bs_1 = b_bs;
            if (i == 3) g0_3 = b_g0;
            if (i == 5) g0_5 = b_g0;
            if (i == 6) begin g0_6 = b_g0; busy_6 = b_busy; end
            doneb = (i == 1) || (i == 5);
        end
        doneb = 1'b0;
        n_cmp++; if (bs_1 !== 1'b1) begin n_bad++; $display("FAIL edge_start: got %b want 1", bs_1); end
        n_cmp++; if (g0_3 !== 1'b1) begin n_bad++; $display("FAIL edge_start_done_ignored: got %b want 1", g0_3); end
        n_cmp++; if (g0_5 !== 1'b1) begin n_bad++; $display("FAIL edge_still_wait: got %b want 1", g0_5); end
        n_cmp++; if (g0_6 !== 1'b0) begin n_bad++; $display("FAIL edge_release: got %b want 0", g0_6); end
        n_cmp++; if (busy_6 !== 1'b1) begin n_bad++; $display("FAIL edge_release_busy: got %b want 1", busy_6); end
        n_cmp++; if (err_cnt !== 0) begin n_bad++; $display("FAIL edge_done_beats_timeout: got %0d want 0", err_cnt); end
    endtask

    task automatic test_async_reset();
        logic g1_2;
        do_reset();
        req1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 0) req1 = 1'b0;
            if (i == 2) g1_2 = a_g1;
        end
        n_cmp++; if (g1_2 !== 1'b1) begin n_bad++; $display("FAIL ar_wait_grant1: got %b want 1", g1_2); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if ({a_g0, a_g1, a_sel, a_bs, a_busy, a_err} !== 6'b0) begin n_bad++; $display("FAIL ar_outs_async: got %b want 000000", {a_g0, a_g1, a_sel, a_bs, a_busy, a_err}); end
        @(negedge clk);
        reset = 1'b0; req0 = 1'b1; req1 = 1'b1;
        @(negedge clk);
        n_cmp++; if ({a_g0, a_g1, a_sel} !== 3'b100) begin n_bad++; $display("FAIL ar_tie_after_reset: got %b want 100", {a_g0, a_g1, a_sel}); end
        run_a(12, 1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_round_robin();
        test_timeout();
        test_done_edges();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
